// File: rtl/ahb2apb_bridge_pkg.sv
// Shared encodings for the AHB-lite to APB3 bridge: AHB transfer types,
// AHB response codes and the bridge FSM state encoding.
package ahb2apb_bridge_pkg;

   // AHB-lite HTRANS encodings
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   // AHB-lite HRESP encodings
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Bridge FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } state_e;

   // Width of the pready timeout counter
   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/ahb2apb_bridge.sv
// AHB-lite slave that turns single AHB transfers into APB3 transfers.
// Registered Moore FSM; a hung peripheral (pready stuck low) is converted
// into a two-cycle AHB ERROR response after TIMEOUT ACCESS cycles.
module ahb2apb_bridge
   import ahb2apb_bridge_pkg::*;
#(
   parameter int unsigned PADDR_W = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   // AHB-lite slave side
   input  logic               hsel,
   input  logic [31:0]        haddr,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [31:0]        hwdata,
   input  logic               hready,
   output logic               hready_out,
   output logic               hresp,
   output logic [31:0]        hrdata,
   // APB3 master side
   output logic [PADDR_W-1:0] paddr,
   output logic               psel,
   output logic               penable,
   output logic               pwrite,
   output logic [31:0]        pwdata,
   input  logic [31:0]        prdata,
   input  logic               pready,
   input  logic               pslverr
);

   // Last counter value before the abort fires; unused when TIMEOUT is 0.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [PADDR_W-1:0] paddr_q;
   logic               pwrite_q;
   logic               psel_q;
   logic               penable_q;
   logic               hready_out_q;
   logic               hresp_q;
   logic [31:0]        hrdata_q;

   logic accept;
   logic start;
   logic timeout_hit;

   // htrans[0] only separates NONSEQ from SEQ, which the bridge treats alike;
   // upper address bits are decoded by the interconnect.
   logic unused_bits;
   assign unused_bits = ^{htrans[0], haddr[31:PADDR_W]};

   assign accept      = hsel & htrans[1] & hready;
   // A new address phase is only taken in states that present hready_out=1.
   assign start       = accept & ((state_q == ST_IDLE) | (state_q == ST_DONE) |
                                  (state_q == ST_ERR2));
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // Next-state decode
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (pready)           state_d = pslverr ? ST_ERR1 : ST_DONE;
            else if (timeout_hit) state_d = ST_ERR1;
         end
         ST_ERR1:   state_d = ST_ERR2;
         ST_DONE,
         ST_ERR2:   state_d = accept ? ST_SETUP : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State, registered outputs decoded from the next state, timeout counter and captures
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         paddr_q      <= '0;
         pwrite_q     <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         hready_out_q <= 1'b1;
         hresp_q      <= HRESP_OKAY;
         hrdata_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         psel_q       <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
         penable_q    <= (state_d == ST_ACCESS);
         hready_out_q <= !((state_d == ST_SETUP) || (state_d == ST_ACCESS) ||
                           (state_d == ST_ERR1));
         hresp_q      <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR
                                                                        : HRESP_OKAY;
         if (start) begin
            paddr_q  <= haddr[PADDR_W-1:0];
            pwrite_q <= hwrite;
         end
         case (state_q)
            ST_SETUP:  cnt_q <= '0;
            ST_ACCESS: begin
               if (!pready) cnt_q <= cnt_q + 1'b1;
               if (pready && !pslverr && !pwrite_q) hrdata_q <= prdata;
            end
            default: ;
         endcase
      end
   end

   assign paddr      = paddr_q;
   assign pwrite     = pwrite_q;
   assign psel       = psel_q;
   assign penable    = penable_q;
   assign hready_out = hready_out_q;
   assign hresp      = hresp_q;
   assign hrdata     = hrdata_q;
   // The master holds hwdata for the whole data phase, spanning SETUP and ACCESS.
   assign pwdata     = hwdata;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge. Two instances share all inputs: one with
// TIMEOUT=4 (main checks) and one with TIMEOUT=0 (never aborts).
module tb_ahb2apb_bridge;
   import ahb2apb_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel, hwrite, hready;
   logic [31:0] haddr, hwdata, prdata;
   logic [1:0]  htrans;
   logic        pready, pslverr;

   logic        hready_out, hresp, psel, penable, pwrite;
   logic [31:0] hrdata, pwdata;
   logic [15:0] paddr;

   logic        nt_hready_out, nt_hresp, nt_psel, nt_penable, nt_pwrite;
   logic [31:0] nt_hrdata, nt_pwdata;
   logic [15:0] nt_paddr;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   ahb2apb_bridge #(.PADDR_W(16), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hready_out(hready_out),
      .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr)
   );

   ahb2apb_bridge #(.PADDR_W(16), .TIMEOUT(0)) dut_nt (
      .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hready_out(nt_hready_out),
      .hresp(nt_hresp), .hrdata(nt_hrdata), .paddr(nt_paddr), .psel(nt_psel),
      .penable(nt_penable), .pwrite(nt_pwrite), .pwdata(nt_pwdata), .prdata(prdata),
      .pready(pready), .pslverr(pslverr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one NONSEQ address phase; on return the bridge is in SETUP.
   task automatic start(input logic [31:0] a, input logic w);
      hsel   = 1'b1;
      htrans = HTRANS_NONSEQ;
      haddr  = a;
      hwrite = w;
      hready = 1'b1;
      cyc();
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
   endtask

   initial begin
      rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      hwdata = '0; hready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      repeat (3) cyc();

      // Reset values
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_hrdata", hrdata, 0);
      check("rst_hresp", hresp, 0);
      check("rst_hready_out", hready_out, 1);
      @(negedge clk) rst_n = 1'b1;
      cyc();

      // 1: zero-wait write
      pready = 1'b1;
      start(32'h4000_0010, 1'b1);
      hwdata = 32'hDEAD_BEEF;
      check("wr_setup_psel", psel, 1);
      check("wr_setup_penable", penable, 0);
      check("wr_setup_paddr", paddr, 32'h0010);
      check("wr_setup_pwrite", pwrite, 1);
      check("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
      check("wr_setup_hready", hready_out, 0);
      cyc();
      check("wr_access_psel", psel, 1);
      check("wr_access_penable", penable, 1);
      check("wr_access_hready", hready_out, 0);
      cyc();
      check("wr_done_hready", hready_out, 1);
      check("wr_done_hresp", hresp, 0);
      check("wr_done_psel", psel, 0);
      check("wr_hrdata_hold", hrdata, 0);
      cyc();
      check("wr_idle_hready", hready_out, 1);

      // 2: read with two APB wait cycles
      pready = 1'b0;
      prdata = 32'h1234_5678;
      start(32'h4000_0024, 1'b0);
      n = 0;
      while (hready_out == 1'b0 && n < 20) begin
         n++;
         if (n == 4) pready = 1'b1;
         cyc();
      end
      check("rd_wait_cycles", n, 4);
      check("rd_hrdata", hrdata, 32'h1234_5678);
      check("rd_hresp", hresp, 0);
      check("rd_paddr", paddr, 32'h0024);
      cyc();

      // 3: write with slave error
      pslverr = 1'b1;
      hwdata  = 32'h0;
      start(32'h4000_0008, 1'b1);
      cyc();
      cyc();
      check("err1_hready", hready_out, 0);
      check("err1_hresp", hresp, 1);
      check("err1_psel", psel, 0);
      cyc();
      check("err2_hready", hready_out, 1);
      check("err2_hresp", hresp, 1);
      cyc();
      check("err_idle_hready", hready_out, 1);
      check("err_idle_hresp", hresp, 0);
      check("err_hrdata_hold", hrdata, 32'h1234_5678);
      pslverr = 1'b0;

      // 5: back-to-back read then write, second accepted in DONE
      prdata = 32'hAAAA_5555;
      start(32'h4000_0030, 1'b0);
      cyc();
      cyc();
      check("b2b_done_hready", hready_out, 1);
      check("b2b_done_paddr", paddr, 32'h0030);
      start(32'h4000_0044, 1'b1);
      check("b2b_setup_psel", psel, 1);
      check("b2b_setup_penable", penable, 0);
      check("b2b_setup_paddr", paddr, 32'h0044);
      check("b2b_setup_pwrite", pwrite, 1);
      check("b2b_hrdata", hrdata, 32'hAAAA_5555);
      cyc();
      cyc();
      cyc();

      // 6a: BUSY, and NONSEQ with hready low, start nothing
      hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h4000_0050;
      repeat (2) cyc();
      check("busy_psel", psel, 0);
      check("busy_hready", hready_out, 1);
      htrans = HTRANS_NONSEQ; hready = 1'b0;
      repeat (2) cyc();
      check("nordy_psel", psel, 0);
      check("nordy_paddr", paddr, 32'h0044);
      hsel = 1'b0; htrans = HTRANS_IDLE; hready = 1'b1;
      cyc();

      // 4: timeout (TIMEOUT=4) versus disabled timeout
      pready = 1'b0;
      start(32'h4000_0060, 1'b1);
      cyc();
      n = 0;
      while (penable == 1'b1 && n < 50) begin
         n++;
         cyc();
      end
      check("to_access_cycles", n, 4);
      check("to_err1_psel", psel, 0);
      check("to_err1_penable", penable, 0);
      check("to_err1_hready", hready_out, 0);
      check("to_err1_hresp", hresp, 1);
      check("nt_still_access", nt_penable, 1);
      cyc();
      check("to_err2_hready", hready_out, 1);
      check("to_err2_hresp", hresp, 1);
      cyc();
      check("to_idle_hresp", hresp, 0);
      repeat (20) cyc();
      check("nt_stall_penable", nt_penable, 1);
      check("nt_stall_psel", nt_psel, 1);
      check("nt_stall_hready", nt_hready_out, 0);

      // 6b: asynchronous reset during ACCESS
      #2 rst_n = 1'b0;
      #1;
      check("arst_psel", nt_psel, 0);
      check("arst_penable", nt_penable, 0);
      check("arst_hready", nt_hready_out, 1);
      @(negedge clk) rst_n = 1'b1;
      cyc();
      check("post_rst_psel", nt_psel, 0);
      check("post_rst_hready", nt_hready_out, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
